// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD digit scanner.
// No logic, so no latency.
// No flow control; everything here is a type or a constant.
package bcd_pkg;

  // One BCD decade.
  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t BCD_MIN = 4'd0;

  // Width of one packed digit in count_o.
  localparam int BCD_W = 4;

endpackage

// File: rtl/bcd_digit_scanner_if.sv
// Count-control and display-drive bundle between control logic and the scanner.
// Wires only, so no latency.
// No flow control: inc/dec/clr are single-cycle strobes and the display outputs are always valid.
interface bcd_digit_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic                        inc_i;
  logic                        dec_i;
  logic                        clr_i;
  logic [4*NUM_DIGITS-1:0]     count_o;
  logic                        ovf_o;
  bcd_pkg::bcd_t               bcd_o;
  logic [NUM_DIGITS-1:0]       an_o;

  // Control side: drives strobes, watches the count and display.
  modport master (
    output inc_i, dec_i, clr_i,
    input  count_o, ovf_o, bcd_o, an_o
  );

  // Scanner side.
  modport slave (
    input  inc_i, dec_i, clr_i,
    output count_o, ovf_o, bcd_o, an_o
  );
endinterface

// File: rtl/bcd_digit_cell.sv
// One BCD decade (0..9) with ripple carry/borrow to the next decade.
// Digit registers on the cycle after a qualified step; carry/borrow out are combinational.
// No flow control: steps whenever its enable and carry/borrow in are both high.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,      // global count-up enable (already excludes clr and inc+dec)
  input  logic dec_i,      // global count-down enable
  input  logic clr_i,      // synchronous clear
  input  logic carry_i,    // all lower decades are 9 (tied high for the LSD)
  input  logic borrow_i,   // all lower decades are 0 (tied high for the LSD)
  output bcd_t digit_o,
  output logic carry_o,
  output logic borrow_o
);

  bcd_t digit_q;
  bcd_t digit_d;

  // Next digit: clear wins, then step up/down only when every lower decade rolls over.
  always_comb begin
    digit_d = digit_q;
    if (clr_i) begin
      digit_d = BCD_MIN;
    end else if (inc_i && carry_i) begin
      digit_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
    end else if (dec_i && borrow_i) begin
      digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
    end
  end

  // Digit state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= BCD_MIN;
    end else begin
      digit_q <= digit_d;
    end
  end

  // Propagate terms are independent of inc/dec so the whole chain settles in one cycle.
  assign carry_o  = carry_i  & (digit_q == BCD_MAX);
  assign borrow_o = borrow_i & (digit_q == BCD_MIN);
  assign digit_o  = digit_q;

endmodule

// File: rtl/bcd_digit_scanner.sv
// Multi-digit BCD up/down counter with time-multiplexed active-low digit scan; LEADING_ZERO_BLANK_EN blanks leading zeros.
// Count, ovf, bcd and anode outputs are registered: one cycle after the input/state they reflect.
// No backpressure: every inc/dec/clr strobe is consumed in the cycle it is presented.
module bcd_digit_scanner
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,     // 2..8
  parameter int SCAN_DIV   = 1000   // clk cycles per digit slot, >= 2
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_digit_scanner_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic                    up_en;
  logic                    dn_en;
  logic [NUM_DIGITS:0]     carry;
  logic [NUM_DIGITS:0]     borrow;
  bcd_t                    digit [NUM_DIGITS];
  logic [4*NUM_DIGITS-1:0] count_w;

  logic                    ovf_q, ovf_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  bcd_t                    bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
`ifdef LEADING_ZERO_BLANK_EN
  logic                    hi_zero;
`endif

  // Clear overrides counting; inc and dec together cancel out.
  assign up_en = bus.inc_i & ~bus.dec_i & ~bus.clr_i;
  assign dn_en = bus.dec_i & ~bus.inc_i & ~bus.clr_i;

  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc_i    (up_en),
      .dec_i    (dn_en),
      .clr_i    (bus.clr_i),
      .carry_i  (carry[g]),
      .borrow_i (borrow[g]),
      .digit_o  (digit[g]),
      .carry_o  (carry[g+1]),
      .borrow_o (borrow[g+1])
    );
    assign count_w[BCD_W*g +: BCD_W] = digit[g];
  end

  // A carry/borrow out of the top decade means the whole count wrapped.
  assign ovf_d = (up_en & carry[NUM_DIGITS]) | (dn_en & borrow[NUM_DIGITS]);

  // Free-running slot divider; the digit index advances on the last cycle of each slot.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Select the scanned digit and its anode; optionally blank it if it is a leading zero.
  always_comb begin
    bcd_d = BCD_MIN;
    an_d  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        bcd_d   = digit[i];
        an_d[i] = 1'b0;
      end
    end
`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the MSD; digit 0 is never blanked so zero still shows "0".
    hi_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      hi_zero = hi_zero & (digit[i] == BCD_MIN);
      if (hi_zero && (idx_q == IDX_W'(i))) begin
        an_d = '1;
      end
    end
`endif
  end

  // Scan state and registered display/overflow outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= '0;
      ovf_q <= 1'b0;
      bcd_q <= BCD_MIN;
      an_q  <= '1;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      ovf_q <= ovf_d;
      bcd_q <= bcd_d;
      an_q  <= an_d;
    end
  end

  assign bus.count_o = count_w;
  assign bus.ovf_o   = ovf_q;
  assign bus.bcd_o   = bcd_q;
  assign bus.an_o    = an_q;

endmodule

// File: tb/tb_bcd_digit_scanner.sv
module tb_bcd_digit_scanner;
  localparam int ND  = 4;
  localparam int DIV = 4;
  localparam int MAXV = 9999;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_digit_scanner_if #(.NUM_DIGITS(ND)) bus ();

  bcd_digit_scanner #(.NUM_DIGITS(ND), .SCAN_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_total = 0;
  int mval = 0;    // reference count as a plain decimal integer
  int cyc = 0;     // clock edges since reset release
  int ovf_seen = 0;

  typedef struct {
    logic        inc;
    logic        dec;
    logic        clr;
    logic [15:0] cnt;
    logic        ovf;
  } vec_t;
  vec_t tbl[10];

  function automatic int pow10(input int e);
    int r = 1;
    for (int k = 0; k < e; k++) r = r * 10;
    return r;
  endfunction

  function automatic int digit_of(input int v, input int i);
    return (v / pow10(i)) % 10;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'(digit_of(v, i));
    return r;
  endfunction

  function automatic logic [3:0] an_for(input int v, input int idx);
    logic [3:0] a;
    a = ~(4'(1) << idx);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx != 0 && v < pow10(idx)) a = 4'hF;
`endif
    return a;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    else n_pass++;
  endtask

  // One clock: drive strobes, advance the reference, compare all outputs #1 after the edge.
  task automatic tick(input logic inc, input logic dec, input logic clr, input bit chk);
    int idx;
    logic [3:0] e_bcd;
    logic [3:0] e_an;
    logic e_ovf;
    bus.inc_i = inc;
    bus.dec_i = dec;
    bus.clr_i = clr;
    idx   = (cyc / DIV) % ND;
    e_bcd = 4'(digit_of(mval, idx));
    e_an  = an_for(mval, idx);
    e_ovf = 1'b0;
    if (clr) mval = 0;
    else if (inc && !dec) begin
      if (mval == MAXV) begin mval = 0; e_ovf = 1'b1; end else mval++;
    end else if (dec && !inc) begin
      if (mval == 0) begin mval = MAXV; e_ovf = 1'b1; end else mval--;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (bus.ovf_o === 1'b1) ovf_seen++;
    if (chk) begin
      check("count", 32'(bus.count_o), 32'(to_bcd(mval)));
      check("ovf", 32'(bus.ovf_o), 32'(e_ovf));
      check("bcd", 32'(bus.bcd_o), 32'(e_bcd));
      check("an", 32'(bus.an_o), 32'(e_an));
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    mval = 0;
  endtask

  initial begin
    logic [3:0] exp_an [4];
    logic [3:0] exp_bcd [4];
    logic [3:0] a;
    bus.inc_i = 1'b0;
    bus.dec_i = 1'b0;
    bus.clr_i = 1'b0;

    // Reset values.
    #12;
    check("rst_count", 32'(bus.count_o), 32'h0);
    check("rst_ovf", 32'(bus.ovf_o), 32'h0);
    check("rst_bcd", 32'(bus.bcd_o), 32'h0);
    check("rst_an", 32'(bus.an_o), 32'hF);
    release_reset();

    // Scan order after release: 4 cycles per slot, all digits 0.
    for (int j = 0; j < 16; j++) begin
      tick(0, 0, 0, 1);
      a = ~(4'(1) << (j / 4));
`ifdef LEADING_ZERO_BLANK_EN
      if (j >= 4) a = 4'hF;
`endif
      check("scan_an", 32'(bus.an_o), 32'(a));
      check("scan_bcd", 32'(bus.bcd_o), 32'h0);
    end

    // 12 incs, then 13 decs with exactly one wrap.
    ovf_seen = 0;
    for (int j = 0; j < 12; j++) tick(1, 0, 0, 1);
    check("inc12", 32'(bus.count_o), 32'h0012);
    check("inc12_noovf", 32'(ovf_seen), 32'd0);
    for (int j = 0; j < 13; j++) tick(0, 1, 0, 1);
    check("dec13", 32'(bus.count_o), 32'h9999);
    check("dec13_ovf1", 32'(ovf_seen), 32'd1);

    // Reset mid-slot, then table-driven strobe combinations.
    tick(1, 0, 0, 1);
    tick(0, 0, 0, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_an", 32'(bus.an_o), 32'hF);
    check("midrst_count", 32'(bus.count_o), 32'h0);
    check("midrst_ovf", 32'(bus.ovf_o), 32'h0);
    bus.inc_i = 1'b0;
    release_reset();

    tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h0001, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 16'h0001, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 16'h9999, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 16'h9999, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 16'h0001, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b0};
    tbl[9] = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0};
    for (int k = 0; k < 10; k++) begin
      tick(tbl[k].inc, tbl[k].dec, tbl[k].clr, 1);
      check($sformatf("tbl%0d_count", k), 32'(bus.count_o), 32'(tbl[k].cnt));
      check($sformatf("tbl%0d_ovf", k), 32'(bus.ovf_o), 32'(tbl[k].ovf));
    end

    // Load 9999 by incrementing, then one more inc wraps with a single-cycle ovf.
    for (int j = 0; j < 9999; j++) tick(1, 0, 0, 0);
    check("load9999", 32'(bus.count_o), 32'h9999);
    tick(1, 0, 0, 1);
    check("upwrap_count", 32'(bus.count_o), 32'h0000);
    check("upwrap_ovf", 32'(bus.ovf_o), 32'h1);
    tick(0, 0, 0, 1);
    check("upwrap_ovf_drop", 32'(bus.ovf_o), 32'h0);

    // inc+dec hold at 0500; clr+inc gives 0000.
    for (int j = 0; j < 500; j++) tick(1, 0, 0, 0);
    tick(1, 1, 0, 1);
    check("hold0500", 32'(bus.count_o), 32'h0500);
    tick(1, 0, 1, 1);
    check("clrinc", 32'(bus.count_o), 32'h0000);
    check("clrinc_ovf", 32'(bus.ovf_o), 32'h0);

    // Count 1234: scan pattern, aligned to the start of slot 0.
    for (int j = 0; j < 1234; j++) tick(1, 0, 0, 0);
    while (cyc % 16 != 0) tick(0, 0, 0, 1);
    exp_an[0] = 4'b1110; exp_an[1] = 4'b1101; exp_an[2] = 4'b1011; exp_an[3] = 4'b0111;
    exp_bcd[0] = 4'd4;   exp_bcd[1] = 4'd3;   exp_bcd[2] = 4'd2;   exp_bcd[3] = 4'd1;
    for (int j = 0; j < 16; j++) begin
      tick(0, 0, 0, 1);
      check("p1234_an", 32'(bus.an_o), 32'(exp_an[j / 4]));
      check("p1234_bcd", 32'(bus.bcd_o), 32'(exp_bcd[j / 4]));
    end
    // Mid-slot change (slot 0 here): bcd follows the new digit one cycle later.
    tick(0, 0, 0, 1);
    tick(1, 0, 0, 1);
    tick(0, 0, 0, 1);
    check("midslot_bcd", 32'(bus.bcd_o), 32'd5);
    check("midslot_an", 32'(bus.an_o), 32'b1110);

    // Count 0042 and 0000 scans (blanking depends on build).
    tick(0, 0, 1, 1);
    for (int j = 0; j < 42; j++) tick(1, 0, 0, 1);
    for (int j = 0; j < 16; j++) tick(0, 0, 0, 1);
    tick(0, 0, 1, 1);
    for (int j = 0; j < 16; j++) tick(0, 0, 0, 1);

    // Randomized strobes against the reference model.
    for (int j = 0; j < 3000; j++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2)       tick(0, 0, 1, 1);
      else if (r < 40) tick(1, 0, 0, 1);
      else if (r < 80) tick(0, 1, 0, 1);
      else if (r < 88) tick(1, 1, 0, 1);
      else             tick(0, 0, 0, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
